// File: rtl/seq1101_sched_pkg.sv
// Shared types for the 1101 round-robin scheduler: controller and detector
// state encodings, plus the detector next-state function.
package seq1101_sched_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } ctrl_state_t;

   typedef enum logic [2:0] {
      S0 = 3'd0,
      S1 = 3'd1,
      S2 = 3'd2,
      S3 = 3'd3,
      S4 = 3'd4
   } det_state_t;

   // S4 is the only match state; a '1' from S4 keeps the "11" prefix alive.
   function automatic det_state_t det_next(input det_state_t s, input logic b);
      det_state_t n;
      case (s)
         S0:      n = b ? S1 : S0;
         S1:      n = b ? S2 : S0;
         S2:      n = b ? S2 : S3;
         S3:      n = b ? S4 : S0;
         S4:      n = b ? S2 : S0;
         default: n = S0;
      endcase
      return n;
   endfunction

endpackage

// File: rtl/seq1101_moore_core.sv
// Moore 1101 detector with synchronous clear and advance enable.
// dout is registered; next_is_match flags that the next state is S4.
module seq1101_moore_core
   import seq1101_sched_pkg::*;
(
   input  logic clk,
   input  logic reset,
   input  logic clr,
   input  logic en,
   input  logic din,
   output logic dout,
   output logic next_is_match
);

   det_state_t state_reg;
   det_state_t state_next;
   logic       dout_reg;

   always_comb begin
      state_next = det_next(state_reg, din);
   end

   assign next_is_match = (state_next == S4);
   assign dout          = dout_reg;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_reg <= S0;
         dout_reg  <= 1'b0;
      end else if (clr) begin
         state_reg <= S0;
         dout_reg  <= 1'b0;
      end else if (en) begin
         state_reg <= state_next;
         dout_reg  <= next_is_match;
      end
   end

endmodule

// File: rtl/seq1101_sched.sv
// Round-robin scheduler sharing one 1101 detector among N_REQ serial
// requesters; one fixed-length frame per grant, hit count reported at the end.
module seq1101_sched
   import seq1101_sched_pkg::*;
#(
   parameter int N_REQ     = 4,
   parameter int FRAME_LEN = 8,
   parameter int CNT_W     = 4
)
(
   input  logic                     clk,
   input  logic                     reset,
   input  logic [N_REQ-1:0]         req,
   input  logic [N_REQ-1:0]         din,
   output logic [N_REQ-1:0]         gnt,
   output logic                     busy,
   output logic                     dout,
   output logic                     done,
   output logic [$clog2(N_REQ)-1:0] done_id,
   output logic [CNT_W-1:0]         hit_cnt
);

   localparam int ID_W = $clog2(N_REQ);
   localparam int BC_W = $clog2(FRAME_LEN);

   ctrl_state_t      state_reg;
   logic [N_REQ-1:0] gnt_reg;
   logic [ID_W-1:0]  cur_id_reg;
   logic [ID_W-1:0]  last_reg;
   logic [BC_W-1:0]  bit_cnt_reg;
   logic [CNT_W-1:0] acc_reg;
   logic             busy_reg;
   logic             done_reg;
   logic [ID_W-1:0]  done_id_reg;
   logic [CNT_W-1:0] hit_cnt_reg;

   logic [ID_W-1:0]  winner;
   logic [N_REQ-1:0] win_onehot;
   logic             start;
   logic             run;
   logic             din_sel;
   logic             next_is_match;
   logic             last_bit;
   logic [CNT_W-1:0] acc_next;

   // Scan from the requester after the last one served, wrapping at N_REQ.
   function automatic logic [ID_W-1:0] rr_pick(input logic [N_REQ-1:0] r,
                                               input logic [ID_W-1:0]  l);
      logic [ID_W-1:0] idx;
      logic [ID_W-1:0] w;
      logic            found;
      idx   = l;
      w     = '0;
      found = 1'b0;
      for (int i = 0; i < N_REQ; i++) begin
         idx = (idx == ID_W'(N_REQ - 1)) ? '0 : idx + ID_W'(1);
         if (!found && r[idx]) begin
            found = 1'b1;
            w     = idx;
         end
      end
      return w;
   endfunction

   assign winner = rr_pick(req, last_reg);

   for (genvar gi = 0; gi < N_REQ; gi++) begin : g_onehot
      assign win_onehot[gi] = (winner == ID_W'(gi));
   end

   assign start    = (state_reg == IDLE) && (|req);
   assign run      = (state_reg == RUN);
   // gnt_reg is one-hot during RUN, so masking picks only the granted lane.
   assign din_sel  = |(din & gnt_reg);
   assign last_bit = (bit_cnt_reg == BC_W'(FRAME_LEN - 1));
   assign acc_next = (next_is_match && (acc_reg != {CNT_W{1'b1}})) ?
                     acc_reg + CNT_W'(1) : acc_reg;

   seq1101_moore_core u_core (
      .clk           (clk),
      .reset         (reset),
      .clr           (start),
      .en            (run),
      .din           (din_sel),
      .dout          (dout),
      .next_is_match (next_is_match)
   );

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_reg   <= IDLE;
         gnt_reg     <= '0;
         cur_id_reg  <= '0;
         last_reg    <= ID_W'(N_REQ - 1);
         bit_cnt_reg <= '0;
         acc_reg     <= '0;
         busy_reg    <= 1'b0;
         done_reg    <= 1'b0;
         done_id_reg <= '0;
         hit_cnt_reg <= '0;
      end else begin
         done_reg <= 1'b0;
         case (state_reg)
            IDLE: begin
               if (|req) begin
                  state_reg   <= RUN;
                  gnt_reg     <= win_onehot;
                  cur_id_reg  <= winner;
                  bit_cnt_reg <= '0;
                  acc_reg     <= '0;
                  busy_reg    <= 1'b1;
               end
            end
            RUN: begin
               bit_cnt_reg <= bit_cnt_reg + BC_W'(1);
               acc_reg     <= acc_next;
               if (last_bit) begin
                  state_reg   <= DONE;
                  gnt_reg     <= '0;
                  done_reg    <= 1'b1;
                  done_id_reg <= cur_id_reg;
                  hit_cnt_reg <= acc_next;
               end
            end
            DONE: begin
               state_reg <= IDLE;
               busy_reg  <= 1'b0;
               last_reg  <= cur_id_reg;
            end
            default: state_reg <= IDLE;
         endcase
      end
   end

   assign gnt     = gnt_reg;
   assign busy    = busy_reg;
   assign done    = done_reg;
   assign done_id = done_id_reg;
   assign hit_cnt = hit_cnt_reg;

endmodule
